// File: rtl/audio_sample_feeder_pkg.sv
// Shared defaults and state encoding for the audio sample feeder.
package audio_sample_feeder_pkg;

  localparam int DEF_FIFO_AW       = 6;
  localparam int DEF_FIFO_DEPTH    = 1 << DEF_FIFO_AW;
  localparam int DEF_SAMPLE_DIV    = 281;
  localparam int DEF_PREFILL_LEVEL = 32;
  localparam int DEF_GAP_TIMEOUT   = 4096;
  localparam int SAMPLE_W          = 24;

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_PLAY    = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/audio_sample_feeder_fifo.sv
// Synchronous sample FIFO, one write and one registered read per cycle.
// A write while full is accepted only when a read frees a slot in the same cycle.
module sample_fifo
  import audio_sample_feeder_pkg::*;
#(
  parameter int AW = DEF_FIFO_AW,
  parameter int DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage array, no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Byte-to-sample assembler, sample-rate tick and prefill/play sequencing
// feeding a held 24-bit mono sample to the I2S driver.
module audio_sample_feeder
  import audio_sample_feeder_pkg::*;
#(
  parameter int FIFO_AW       = DEF_FIFO_AW,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int PREFILL_LEVEL = DEF_PREFILL_LEVEL,
  parameter int GAP_TIMEOUT   = DEF_GAP_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                clear_flags,
  output logic [23:0]         mono_sample,
  output logic                sample_tick,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                playing,
  output logic                underrun,
  output logic                overflow
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int GW = $clog2(GAP_TIMEOUT);
  localparam logic [TW-1:0]    TICK_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_TIMEOUT - 1);
  localparam logic [FIFO_AW:0] PREFILL_LV = (FIFO_AW + 1)'(PREFILL_LEVEL);

  logic [TW-1:0] tick_cnt;
  logic [1:0]    byte_idx;
  logic [15:0]   asm_lo;
  logic [GW-1:0] gap_cnt;
  logic          push;
  logic [23:0]   push_word;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [23:0]   fifo_data;
  logic          out_zero;
  logic          set_underrun;
  logic          set_overflow;
  feeder_state_e state, state_nxt;

  assign push         = rx_valid && (byte_idx == 2'd2);
  assign push_word    = {rx_data, asm_lo};
  assign sample_tick  = (tick_cnt == TICK_LAST);
  assign playing      = (state == ST_PLAY);
  assign set_overflow = push && fifo_full && !pop;
  // Silence is selected by a flag rather than by clearing the FIFO read register.
  assign mono_sample  = out_zero ? 24'd0 : fifo_data;

  sample_fifo #(
    .AW (FIFO_AW),
    .DW (24)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Free-running sample-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Little-endian byte assembly with idle-gap resynchronisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= 2'd0;
      asm_lo   <= '0;
      gap_cnt  <= '0;
    end else if (rx_valid) begin
      gap_cnt <= '0;
      case (byte_idx)
        2'd0: begin
          asm_lo[7:0] <= rx_data;
          byte_idx    <= 2'd1;
        end
        2'd1: begin
          asm_lo[15:8] <= rx_data;
          byte_idx     <= 2'd2;
        end
        default: byte_idx <= 2'd0;
      endcase
    end else if (byte_idx != 2'd0) begin
      if (gap_cnt == GAP_LAST) begin
        byte_idx <= 2'd0;
        gap_cnt  <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PREFILL;
    else state <= state_nxt;
  end

  // Next state, pop request and underrun detection.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    set_underrun = 1'b0;
    case (state)
      ST_PREFILL: begin
        if (fifo_level >= PREFILL_LV) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (sample_tick) begin
          if (fifo_empty) begin
            set_underrun = 1'b1;
            state_nxt    = ST_PREFILL;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_nxt = ST_PREFILL;
    endcase
  end

  // Output is silent after any tick that did not pop a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_zero <= 1'b1;
    else if (sample_tick) out_zero <= !pop;
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (set_underrun) underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
      if (set_overflow) overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder at default parameters.
module tb_audio_sample_feeder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        clear_flags;
  logic [23:0] mono_sample;
  logic        sample_tick;
  logic [6:0]  fifo_level;
  logic        playing;
  logic        underrun;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  audio_sample_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .clear_flags (clear_flags),
    .mono_sample (mono_sample),
    .sample_tick (sample_tick),
    .fifo_level  (fifo_level),
    .playing     (playing),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns in the same phase.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  // Returns in a cycle where sample_tick is high (before the acting edge).
  task automatic wait_tick_high(input string tag);
    int n;
    n = 0;
    while (sample_tick !== 1'b1 && n < 400) begin
      cycle();
      n++;
    end
    chk(tag, {31'd0, sample_tick}, 32'd1);
  endtask

  // Returns one cycle after a tick, when its effects are visible.
  task automatic wait_tick(input string tag);
    wait_tick_high(tag);
    cycle();
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    clear_flags = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mono", {8'd0, mono_sample}, 32'd0);
    chk("rst_tick", {31'd0, sample_tick}, 32'd0);
    chk("rst_level", {25'd0, fifo_level}, 32'd0);
    chk("rst_playing", {31'd0, playing}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    #3 rst_n = 1'b1;
    cycle();

    // Prefill 32 samples of 0x030201, then first pop
    for (int i = 0; i < 32; i++) send_sample(8'h01, 8'h02, 8'h03);
    chk("pf_level32", {25'd0, fifo_level}, 32'd32);
    chk("pf_not_yet_playing", {31'd0, playing}, 32'd0);
    cycle();
    chk("pf_playing", {31'd0, playing}, 32'd1);
    wait_tick("t1_tick");
    chk("t1_mono", {8'd0, mono_sample}, 32'h030201);
    chk("t1_level", {25'd0, fifo_level}, 32'd31);
    chk("t1_tick_pulse", {31'd0, sample_tick}, 32'd0);

    // Drain without input, then underrun
    for (int i = 0; i < 31; i++) wait_tick("drain_tick");
    chk("drain_level", {25'd0, fifo_level}, 32'd0);
    chk("drain_mono", {8'd0, mono_sample}, 32'h030201);
    chk("drain_no_underrun", {31'd0, underrun}, 32'd0);
    wait_tick("ur_tick");
    chk("ur_mono", {8'd0, mono_sample}, 32'd0);
    chk("ur_flag", {31'd0, underrun}, 32'd1);
    chk("ur_playing", {31'd0, playing}, 32'd0);
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    chk("ur_cleared", {31'd0, underrun}, 32'd0);

    // Gap timeout discards partial bytes; short gap does not
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (4100) cycle();
    send_sample(8'hAA, 8'hBB, 8'hCC);
    chk("gap_level1", {25'd0, fifo_level}, 32'd1);
    send_byte(8'h44);
    send_byte(8'h55);
    repeat (50) cycle();
    send_byte(8'h66);
    chk("gap_level2", {25'd0, fifo_level}, 32'd2);
    for (int i = 0; i < 30; i++) send_sample(8'h10, 8'h20, 8'h30);
    cycle();
    chk("gap_playing", {31'd0, playing}, 32'd1);
    wait_tick("gap_tick1");
    chk("gap_word1", {8'd0, mono_sample}, 32'hCCBBAA);
    wait_tick("gap_tick2");
    chk("gap_word2", {8'd0, mono_sample}, 32'h665544);
    chk("gap_level30", {25'd0, fifo_level}, 32'd30);

    // Asynchronous reset mid-stream
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mono", {8'd0, mono_sample}, 32'd0);
    chk("arst_level", {25'd0, fifo_level}, 32'd0);
    chk("arst_playing", {31'd0, playing}, 32'd0);
    chk("arst_tick", {31'd0, sample_tick}, 32'd0);
    #2 rst_n = 1'b1;
    cycle();

    // Overflow: 70 pushes before the first tick
    for (int i = 0; i < 70; i++) begin
      send_sample(8'(i), 8'(i), 8'hA0);
      if (i == 63) begin
        chk("ov_full_level", {25'd0, fifo_level}, 32'd64);
        chk("ov_not_yet", {31'd0, overflow}, 32'd0);
      end
    end
    chk("ov_level", {25'd0, fifo_level}, 32'd64);
    chk("ov_flag", {31'd0, overflow}, 32'd1);
    chk("ov_playing", {31'd0, playing}, 32'd1);

    // Clear coinciding with a drop: set wins; clear alone clears
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    chk("clr_alone_pre", {31'd0, overflow}, 32'd0);
    send_byte(8'h77);
    send_byte(8'h77);
    clear_flags = 1'b1;
    send_byte(8'h77);
    clear_flags = 1'b0;
    chk("clr_set_wins", {31'd0, overflow}, 32'd1);
    chk("clr_level", {25'd0, fifo_level}, 32'd64);
    clear_flags = 1'b1;
    cycle();
    clear_flags = 1'b0;
    chk("clr_alone", {31'd0, overflow}, 32'd0);

    // Full FIFO: push coinciding with tick pop
    send_byte(8'h5A);
    send_byte(8'h5B);
    wait_tick_high("fp_tick");
    send_byte(8'h5C);
    chk("fp_level", {25'd0, fifo_level}, 32'd64);
    chk("fp_overflow", {31'd0, overflow}, 32'd0);
    chk("fp_mono", {8'd0, mono_sample}, 32'hA00000);
    wait_tick("fp_tick2");
    chk("fp_mono2", {8'd0, mono_sample}, 32'hA00101);
    chk("fp_level2", {25'd0, fifo_level}, 32'd63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
